// File: rtl/legv8_pkg.sv
// legv8_pkg: shared state, instruction-class, opcode and mux encodings for the multi-cycle control.
package legv8_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, TRAP
  } state_t;
  typedef enum logic [2:0] {IC_R, IC_LD, IC_ST, IC_CBZ, IC_ILL} iclass_t;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [1:0] ASB_B   = 2'b00;
  localparam logic [1:0] ASB_4   = 2'b01;
  localparam logic [1:0] ASB_IMM = 2'b10;
  localparam logic [1:0] ASB_BR  = 2'b11;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
endpackage

// File: rtl/ctrl_opdec.sv
// ctrl_opdec: maps the IR opcode field onto an instruction class.
module ctrl_opdec
  import legv8_pkg::*;
#(
  parameter int OPW = 11
) (
  input  logic [OPW-1:0] op,
  output iclass_t        cls
);
  logic is_r;
  assign is_r = op == OPW'(OP_ADD) || op == OPW'(OP_SUB) || op == OPW'(OP_AND) || op == OPW'(OP_ORR);
  always_comb begin
    cls = is_r                   ? IC_R   :
          op == OPW'(OP_LDUR)    ? IC_LD  :
          op == OPW'(OP_STUR)    ? IC_ST  :
          op[OPW-1 -: 8] == OP_CBZ ? IC_CBZ : IC_ILL;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: LEGv8 multi-cycle control FSM; MULTICYCLE_ILLEGAL_TRAP_EN enables the illegal-opcode TRAP state.
module multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int OPW = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           mem_addr_sel,
  output logic           ir_we,
  output logic           pc_we,
  output logic           mdr_we,
  output logic           reg_we,
  output logic           pc_src,
  output logic           wb_sel,
  output logic           reg2loc,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [3:0]     state,
  output logic           exc
);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  localparam state_t ILL_NXT = TRAP;
`else
  localparam state_t ILL_NXT = FETCH;
`endif
  state_t  st, nxt;
  iclass_t cls;
  ctrl_opdec #(.OPW(OPW)) u_opdec (.op(op), .cls(cls));
  always_ff @(posedge clk) begin
    if (reset) st <= FETCH;
    else       st <= nxt;
  end
  assign state = st;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign exc = !reset && st == TRAP;
`else
  assign exc = 1'b0;
`endif
  always_comb begin
    nxt          = st;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    mdr_we       = 1'b0;
    reg_we       = 1'b0;
    pc_src       = 1'b0;
    wb_sel       = 1'b0;
    reg2loc      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = ASB_B;
    alu_op       = ALU_ADD;
    case (st)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ASB_4;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = ASB_BR;
        reg2loc   = cls == IC_ST || cls == IC_CBZ;
        nxt       = cls == IC_R              ? EXEC_R   :
                    cls == IC_LD || cls == IC_ST ? MEM_ADDR :
                    cls == IC_CBZ            ? BRANCH   : ILL_NXT;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        nxt       = ALU_WB;
      end
      ALU_WB: begin
        reg_we = 1'b1;
        nxt    = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        nxt       = cls == IC_LD ? MEM_RD : cls == IC_ST ? MEM_WR : FETCH;
      end
      MEM_RD: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mdr_we       = mem_ready;
        nxt          = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_we = 1'b1;
        wb_sel = 1'b1;
        nxt    = FETCH;
      end
      MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = 1'b1;
        reg2loc      = 1'b1;
        nxt          = mem_ready ? FETCH : MEM_WR;
      end
      BRANCH: begin
        reg2loc   = 1'b1;
        alu_src_a = 1'b1;
        alu_op    = ALU_PASSB;
        pc_we     = zero;
        pc_src    = zero;
        nxt       = FETCH;
      end
      TRAP:    nxt = TRAP;
      default: nxt = FETCH;
    endcase
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      mdr_we       = 1'b0;
      reg_we       = 1'b0;
      pc_src       = 1'b0;
      wb_sel       = 1'b0;
      reg2loc      = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = ASB_B;
      alu_op       = ALU_ADD;
    end
  end
endmodule
